// File: rtl/sram_like_responder.sv
// ============================================================================
// Module   : sram_like_responder
// Brief    : Responder side of the SRAM-like req/addr_ok/data_ok interface,
//            backed by a 1-cycle synchronous RAM port with in-order responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_responder #(
    parameter int DEPTH      = 2,
    parameter int DATA_LAT   = 1,
    parameter int RAND_STALL = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int CW = $clog2(DATA_LAT + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAT_LOAD   = CW'(DATA_LAT - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [NW-1:0] COUNT_FULL = NW'(DEPTH);
    localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] q_write;
    logic [DEPTH-1:0] q_dvalid;
    logic [31:0]      q_data [DEPTH];
    logic [CW-1:0]    q_cnt  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [NW-1:0] count;
    logic [15:0]   lfsr;

    // Read accepted last cycle: its RAM data is on ram_rdata this cycle.
    logic          rd_pend;
    logic [PW-1:0] rd_idx;

    logic stall_ok;
    logic accept;
    logic head_arrive;
    logic unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Size and byte offset do not influence a word-wide RAM access.
    assign unused_bits = ^{size, addr[1:0]};

    assign stall_ok    = (RAND_STALL != 0) ? lfsr[0] : 1'b1;
    assign addr_ok     = ~reset & req & (count < COUNT_FULL) & stall_ok;
    assign accept      = req & addr_ok;

    assign ram_en      = accept;
    assign ram_addr    = {addr[31:2], 2'b00};
    assign ram_we      = (accept & wr) ? wstrb : 4'b0000;
    assign ram_wdata   = wdata;

    assign head_arrive = rd_pend & (rd_idx == head);
    assign data_ok     = ~reset & q_valid[head] & (q_cnt[head] == '0)
                       & (q_dvalid[head] | head_arrive);

    always_comb begin
        rdata = 32'h0;
        if (data_ok && !q_write[head]) begin
            rdata = head_arrive ? ram_rdata : q_data[head];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid  <= '0;
            q_write  <= '0;
            q_dvalid <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            lfsr     <= LFSR_SEED;
            rd_pend  <= 1'b0;
            rd_idx   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= 32'h0;
                q_cnt[i]  <= '0;
            end
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

            for (int i = 0; i < DEPTH; i++) begin
                if (q_valid[i] && q_cnt[i] != '0) begin
                    q_cnt[i] <= q_cnt[i] - 1'b1;
                end
            end

            if (rd_pend) begin
                q_data[rd_idx]   <= ram_rdata;
                q_dvalid[rd_idx] <= 1'b1;
            end

            if (data_ok) begin
                q_valid[head] <= 1'b0;
                head          <= ptr_inc(head);
            end

            // Tail slot is free whenever accept is possible, so this never
            // collides with the head or the pending-read slot.
            if (accept) begin
                q_valid[tail]  <= 1'b1;
                q_write[tail]  <= wr;
                q_dvalid[tail] <= wr;
                q_data[tail]   <= 32'h0;
                q_cnt[tail]    <= LAT_LOAD;
                tail           <= ptr_inc(tail);
            end

            rd_pend <= accept & ~wr;
            rd_idx  <= tail;

            case ({accept, data_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_like_responder.sv
// ============================================================================
// Module   : tb_sram_like_responder
// Brief    : Directed and LFSR-stall bench for sram_like_responder over four
//            parameterisations, each with its own byte-enabled RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        addr_ok   [4];
    logic        data_ok   [4];
    logic [31:0] rdata     [4];
    logic        ram_en    [4];
    logic [3:0]  ram_we    [4];
    logic [31:0] ram_addr  [4];
    logic [31:0] ram_wdata [4];
    logic [31:0] ram_rdata [4];

    logic [31:0] mem [4][256];

    int n_checks;
    int n_fail;

    // 0: DEPTH2/LAT1, 1: DEPTH2/LAT3, 2: DEPTH2/LAT4, 3: DEPTH4/LAT2 random stall
    sram_like_responder #(.DEPTH(2), .DATA_LAT(1), .RAND_STALL(0)) u_lat1 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
        .rdata(rdata[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]));

    sram_like_responder #(.DEPTH(2), .DATA_LAT(3), .RAND_STALL(0)) u_lat3 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
        .rdata(rdata[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]));

    sram_like_responder #(.DEPTH(2), .DATA_LAT(4), .RAND_STALL(0)) u_lat4 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]),
        .rdata(rdata[2]), .ram_en(ram_en[2]), .ram_we(ram_we[2]), .ram_addr(ram_addr[2]),
        .ram_wdata(ram_wdata[2]), .ram_rdata(ram_rdata[2]));

    sram_like_responder #(.DEPTH(4), .DATA_LAT(2), .RAND_STALL(1)) u_rand (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok[3]), .data_ok(data_ok[3]),
        .rdata(rdata[3]), .ram_en(ram_en[3]), .ram_we(ram_we[3]), .ram_addr(ram_addr[3]),
        .ram_wdata(ram_wdata[3]), .ram_rdata(ram_rdata[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs: read data appears the cycle after ram_en.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ram_en[k]) begin
                ram_rdata[k] <= mem[k][ram_addr[k][9:2]];
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[k][b]) mem[k][ram_addr[k][9:2]][8*b +: 8] <= ram_wdata[k][8*b +: 8];
                end
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        req = r; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of the first cycle out of reset.
    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if ({addr_ok[k], data_ok[k], ram_en[k], rdata[k]} !== 35'h0) begin
                    n_fail++;
                    $display("FAIL reset_outputs dut%0d: addr_ok=%b data_ok=%b ram_en=%b rdata=%h, required all 0",
                             k, addr_ok[k], data_ok[k], ram_en[k], rdata[k]);
                end
            end
            next_cycle();
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_single_read();
        logic [2:0] dok_tbl;
        do_reset();
        mem[0][0] = 32'h0280_0c0c;
        dok_tbl = 3'b010;
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 1'b0, 32'h1c00_0000, 4'h0, 32'h0);
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (addr_ok[0] !== 1'b1 || ram_en[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_read_accept: addr_ok=%b ram_en=%b, required 1 1", addr_ok[0], ram_en[0]);
                end
            end
            n_checks++;
            if (data_ok[0] !== dok_tbl[c]) begin
                n_fail++;
                $display("FAIL single_read_data_ok cycle %0d: got %b, required %b", c, data_ok[0], dok_tbl[c]);
            end
            if (c == 1) begin
                n_checks++;
                if (rdata[0] !== 32'h0280_0c0c) begin
                    n_fail++;
                    $display("FAIL single_read_rdata: got %h, required 02800c0c", rdata[0]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_depth_stall();
        logic [8:0]  aok_tbl;
        logic [8:0]  dok_tbl;
        logic [31:0] exp_d [3];
        int nacc;
        int nresp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_d[i] = 32'hA0A0_0000 + 32'(i);
            mem[1][i] = exp_d[i];
        end
        aok_tbl = 9'b0_0001_0011;
        dok_tbl = 9'b0_1001_1000;
        nacc = 0;
        nresp = 0;
        for (int c = 0; c < 9; c++) begin
            drive(nacc < 3, 1'b0, 32'(nacc * 4), 4'h0, 32'h0);
            @(negedge clk);
            n_checks++;
            if (addr_ok[1] !== aok_tbl[c]) begin
                n_fail++;
                $display("FAIL depth_addr_ok cycle %0d: got %b, required %b", c, addr_ok[1], aok_tbl[c]);
            end
            n_checks++;
            if (data_ok[1] !== dok_tbl[c]) begin
                n_fail++;
                $display("FAIL depth_data_ok cycle %0d: got %b, required %b", c, data_ok[1], dok_tbl[c]);
            end
            if (dok_tbl[c] && nresp < 3) begin
                n_checks++;
                if (rdata[1] !== exp_d[nresp]) begin
                    n_fail++;
                    $display("FAIL depth_rdata resp %0d: got %h, required %h", nresp, rdata[1], exp_d[nresp]);
                end
                nresp++;
            end
            if (req && addr_ok[1]) nacc++;
            next_cycle();
        end
    endtask

    task automatic test_write_then_read();
        logic [5:0] dok_tbl;
        logic [31:0] exp_r [6];
        do_reset();
        mem[1][64] = 32'h1122_3344;
        dok_tbl = 6'b01_1000;
        exp_r[3] = 32'h0;
        exp_r[4] = 32'h1122_CCDD;
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      drive(1'b1, 1'b1, 32'h0000_0102, 4'b0011, 32'hAABB_CCDD);
            else if (c == 1) drive(1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h5555_5555);
            else             drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (addr_ok[1] !== 1'b1 || ram_addr[1] !== 32'h100 || ram_we[1] !== 4'b0011
                    || ram_wdata[1] !== 32'hAABB_CCDD) begin
                    n_fail++;
                    $display("FAIL write_port: addr_ok=%b ram_addr=%h ram_we=%b ram_wdata=%h, required 1 00000100 0011 aabbccdd",
                             addr_ok[1], ram_addr[1], ram_we[1], ram_wdata[1]);
                end
            end
            if (c == 1) begin
                n_checks++;
                if (addr_ok[1] !== 1'b1 || ram_we[1] !== 4'b0000 || ram_addr[1] !== 32'h100) begin
                    n_fail++;
                    $display("FAIL read_port: addr_ok=%b ram_we=%b ram_addr=%h, required 1 0000 00000100",
                             addr_ok[1], ram_we[1], ram_addr[1]);
                end
            end
            n_checks++;
            if (data_ok[1] !== dok_tbl[c]) begin
                n_fail++;
                $display("FAIL wr_rd_data_ok cycle %0d: got %b, required %b", c, data_ok[1], dok_tbl[c]);
            end
            if (dok_tbl[c]) begin
                n_checks++;
                if (rdata[1] !== exp_r[c]) begin
                    n_fail++;
                    $display("FAIL wr_rd_rdata cycle %0d: got %h, required %h", c, rdata[1], exp_r[c]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pat [8];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pat[i] = 32'h5A5A_0000 + 32'(i) * 32'h0101;
            mem[0][i] = pat[i];
        end
        for (int c = 0; c < 9; c++) begin
            drive(c < 8, 1'b0, 32'(c * 4), 4'h0, 32'h0);
            @(negedge clk);
            n_checks++;
            if (addr_ok[0] !== (c < 8)) begin
                n_fail++;
                $display("FAIL b2b_addr_ok cycle %0d: got %b, required %b", c, addr_ok[0], c < 8);
            end
            n_checks++;
            if (data_ok[0] !== (c >= 1)) begin
                n_fail++;
                $display("FAIL b2b_data_ok cycle %0d: got %b, required %b", c, data_ok[0], c >= 1);
            end
            if (c >= 1) begin
                n_checks++;
                if (rdata[0] !== pat[c-1]) begin
                    n_fail++;
                    $display("FAIL b2b_rdata cycle %0d: got %h, required %h", c, rdata[0], pat[c-1]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        mem[2][5] = 32'hCAFE_F00D;
        for (int c = 0; c < 17; c++) begin
            reset = (c == 2);
            if (c == 0 || c == 1) drive(1'b1, 1'b0, 32'(c * 4), 4'h0, 32'h0);
            else if (c == 2)      drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
            else if (c == 11)     drive(1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
            else                  drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            if (c == 0 || c == 1 || c == 11) begin
                n_checks++;
                if (addr_ok[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midrst_accept cycle %0d: got %b, required 1", c, addr_ok[2]);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (addr_ok[2] !== 1'b0 || ram_en[2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_in_reset: addr_ok=%b ram_en=%b, required 0 0", addr_ok[2], ram_en[2]);
                end
            end
            n_checks++;
            if (data_ok[2] !== (c == 15)) begin
                n_fail++;
                $display("FAIL midrst_data_ok cycle %0d: got %b, required %b", c, data_ok[2], c == 15);
            end
            if (c == 15) begin
                n_checks++;
                if (rdata[2] !== 32'hCAFE_F00D) begin
                    n_fail++;
                    $display("FAIL midrst_rdata: got %h, required cafef00d", rdata[2]);
                end
            end
            next_cycle();
        end
        reset = 1'b0;
    endtask

    typedef struct {
        int          due;
        logic        isw;
        logic [31:0] data;
    } exp_t;

    task automatic test_random_stall();
        exp_t        q[$];
        exp_t        e;
        logic [31:0] refm [16];
        logic [15:0] lfsr_m;
        logic        exp_aok;
        logic        exp_dok;
        int          cyc;
        int          acc;
        int          last_due;
        int          idx;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            refm[i]   = 32'h0;
            mem[3][i] = 32'h0;
        end
        lfsr_m   = 16'hACE1;
        cyc      = 0;
        acc      = 0;
        last_due = -1;
        while ((acc < 200 || q.size() != 0) && cyc < 6000) begin
            drive((acc < 200) && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), 4'($urandom), $urandom);
            exp_aok = req && lfsr_m[0] && (q.size() < 4);
            @(negedge clk);
            n_checks++;
            if (addr_ok[3] !== exp_aok) begin
                n_fail++;
                $display("FAIL rand_addr_ok cycle %0d: got %b, required %b", cyc, addr_ok[3], exp_aok);
            end
            exp_dok = (q.size() != 0) && (q[0].due == cyc);
            n_checks++;
            if (data_ok[3] !== exp_dok) begin
                n_fail++;
                $display("FAIL rand_data_ok cycle %0d: got %b, required %b", cyc, data_ok[3], exp_dok);
            end
            if (exp_dok) begin
                e = q.pop_front();
                n_checks++;
                if (rdata[3] !== (e.isw ? 32'h0 : e.data)) begin
                    n_fail++;
                    $display("FAIL rand_rdata cycle %0d: got %h, required %h",
                             cyc, rdata[3], e.isw ? 32'h0 : e.data);
                end
            end
            if (exp_aok) begin
                idx   = int'(addr[5:2]);
                e.isw = wr;
                e.data = 32'h0;
                if (wr) begin
                    for (int b = 0; b < 4; b++) if (wstrb[b]) refm[idx][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    e.data = refm[idx];
                end
                e.due    = (cyc + 2 > last_due + 1) ? cyc + 2 : last_due + 1;
                last_due = e.due;
                q.push_back(e);
                acc++;
            end
            lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
            cyc++;
            next_cycle();
        end
        n_checks++;
        if (acc != 200 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_completion: accepted %0d outstanding %0d, required 200 and 0", acc, q.size());
        end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) mem[k][i] = 32'h0;
        end
        test_reset();
        test_single_read();
        test_depth_stall();
        test_write_then_read();
        test_back_to_back();
        test_mid_reset();
        test_random_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Slave (responder) end of the SRAM-like request/response interface driven by the fetch and memory-access stages: req/wr/size/wstrb/addr/wdata out, addr_ok/data_ok/rdata back.
- Accepts requests with addr_ok and issues each accepted request to a 1-cycle synchronous RAM port.
- Tracks up to DEPTH outstanding transactions and returns exactly one in-order data_ok per accepted request after a configurable latency.
- Optional pseudo-random addr_ok stalling exercises initiator stall/cancel paths.

Parameters:
- DEPTH, 2, maximum outstanding (accepted, not yet data_ok) requests; power of two, 1..8.
- DATA_LAT, 1, cycles from acceptance cycle to data_ok cycle; minimum 1.
- RAND_STALL, 0, 1 = additionally gate addr_ok with LFSR bit 0.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word. Informational; reads always return a full word.
- wstrb  in  4  write byte enables.
- addr  in  32  byte address.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle (when req high).
- data_ok  out  1  one-cycle response pulse.
- rdata  out  32  read data, valid when data_ok.
- ram_en  out  1  RAM access strobe.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  32  word-aligned RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en.

Behaviour:
- Reset (synchronous): outstanding count = 0; all queue entries invalid; LFSR = 16'hACE1. While reset is high, addr_ok, data_ok and ram_en are 0 and rdata is 0.
- Combinational outputs:
  - addr_ok = ~reset & req & (count < DEPTH) & (RAND_STALL ? lfsr[0] : 1).
  - Handshake: accept = req & addr_ok. addr_ok never depends on same-cycle data_ok.
  - ram_en = accept.
  - ram_addr = {addr[31:2], 2'b00}.
  - ram_we = (accept & wr) ? wstrb : 4'b0.
  - ram_wdata = wdata.
- Request queue: circular FIFO, DEPTH entries, head/tail pointers wrap modulo DEPTH. Each entry holds valid, is_write, data_valid, data[31:0] and countdown[ceil(log2(DATA_LAT+1))-1:0].
  - On accept, the tail entry is loaded with countdown = DATA_LAT-1, data_valid = is_write, data = 0.
  - Every valid entry with countdown != 0 decrements each cycle.
  - A read entry captures ram_rdata (data_valid <= 1) on the edge ending the cycle after its acceptance.
- Response:
  - data_ok = head valid & head countdown == 0 & (head data_valid | head read data arriving this cycle).
  - rdata = bypass ram_rdata if the head's read data arrives this cycle; otherwise head data. rdata is 0 for writes and 0 when data_ok is low.
  - On data_ok the head is invalidated and the head pointer advances. There is no back-pressure on data_ok.
- Latency: a request accepted in cycle c gets data_ok in cycle c+DATA_LAT when the queue ahead of it is drained. Otherwise it comes in the cycle after the previous data_ok, whichever is later. Responses are strictly in acceptance order.
- Count: +1 on accept, -1 on data_ok, unchanged when both occur in the same cycle. Count never exceeds DEPTH and never underflows.
- Ordering: RAM is accessed in acceptance order, so read-after-write to the same address returns the new data.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11; shifts every cycle when not in reset. It is present but unused when RAND_STALL = 0.
- Reset mid-operation: all pending responses are dropped and no data_ok is produced for requests accepted before reset.

Test Plan:
1. DATA_LAT=1: RAM[0x1c000000] = 0x02800c0c; req read addr 0x1c000000 in cycle 0 -> addr_ok=1 and ram_en=1 in cycle 0; data_ok=1 with rdata=0x02800c0c in cycle 1; data_ok=0 in cycle 2.
2. DEPTH=2, DATA_LAT=3, continuous read req to 0x0, 0x4, 0x8 -> addr_ok high cycles 0 and 1, low cycles 2–3; data_ok cycles 3 and 4 in order; third request accepted cycle 4, data_ok cycle 7.
3. Write, wr=1, wstrb=4'b0011, addr=0x102, wdata=0xAABBCCDD -> ram_addr=0x100, ram_we=4'b0011; data_ok after DATA_LAT with rdata=0. An immediate read of 0x100 returns the updated bytes.
4. DEPTH=2, DATA_LAT=1, back-to-back reads -> accept and data_ok in the same cycle; count stays 1; one data_ok per cycle, all data correct.
5. Two outstanding reads, DATA_LAT=4, reset pulsed in cycle 2 -> no data_ok ever for them; count=0; addr_ok=0 during reset; a fresh read after reset completes normally.
6. RAND_STALL=1, 200 random reads and writes -> addr_ok follows lfsr[0]; every accepted request gets exactly one data_ok in order; read data matches the reference memory model.
